// File: rtl/hvsync_pkg.sv
// Shared constants and types for the hvsync_generator pixel pipeline.
package hvsync_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned H_LEN     = 9;
  localparam int unsigned V_LEN     = 9;

  // Colour encoding is {b,g,r}
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BORDER = 3'b010;
  localparam logic [2:0] COL_BALL   = 3'b111;
  localparam logic [2:0] COL_BG     = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD_X = 2'd1,
    UPD_Y = 2'd2
  } ball_state_t;

endpackage

// File: rtl/bounce_axis.sv
// One axis of ball motion: position plus direction, bouncing between 0 and LIM.
module bounce_axis #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LIM   = 624,
  parameter int unsigned SPEED = 2,
  parameter int unsigned START = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [WIDTH-1:0] pos,
  output logic             dir
);

  localparam logic [WIDTH-1:0] LimW   = WIDTH'(LIM);
  localparam logic [WIDTH-1:0] SpeedW = WIDTH'(SPEED);

  logic [WIDTH-1:0] pos_d;
  logic             dir_d;

  // Next position: clamp to the edge and flip direction when the step would reach it
  always_comb begin
    pos_d = pos;
    dir_d = dir;
    if (dir) begin
      if (pos + SpeedW >= LimW) begin
        pos_d = LimW;
        dir_d = 1'b0;
      end else begin
        pos_d = pos + SpeedW;
      end
    end else begin
      if (pos <= SpeedW) begin
        pos_d = '0;
        dir_d = 1'b1;
      end else begin
        pos_d = pos - SpeedW;
      end
    end
  end

  // Position/direction state, advanced only on step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= WIDTH'(START);
      dir <= 1'b1;
    end else if (step) begin
      pos <= pos_d;
      dir <= dir_d;
    end
  end

endmodule

// File: rtl/ball_renderer.sv
// Draws a one-pixel border and a bouncing square ball; syncs delayed to match rgb.
module ball_renderer #(
  parameter int unsigned H_LEN     = hvsync_pkg::H_LEN,
  parameter int unsigned V_LEN     = hvsync_pkg::V_LEN,
  parameter int unsigned H_DISPLAY = hvsync_pkg::H_DISPLAY,
  parameter int unsigned V_DISPLAY = hvsync_pkg::V_DISPLAY,
  parameter int unsigned BALL_SIZE = 16,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned START_X   = 100,
  parameter int unsigned START_Y   = 80
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic           display_on,
  input  logic [H_LEN:0] hpos,
  input  logic [V_LEN:0] vpos,
  input  logic           pause,
  output logic           hsync,
  output logic           vsync,
  output logic [2:0]     rgb
);

  import hvsync_pkg::*;

  localparam int unsigned HW = H_LEN + 1;
  localparam int unsigned VW = V_LEN + 1;

  localparam logic [HW-1:0] HLast = HW'(H_DISPLAY - 1);
  localparam logic [VW-1:0] VLast = VW'(V_DISPLAY - 1);
  localparam logic [VW-1:0] VTick = VW'(V_DISPLAY);
  localparam logic [HW-1:0] BallH = HW'(BALL_SIZE);
  localparam logic [VW-1:0] BallV = VW'(BALL_SIZE);

  ball_state_t   state_q, state_d;
  logic          armed_q;
  logic          tick, accept;
  logic [HW-1:0] ball_x;
  logic [VW-1:0] ball_y;
  logic          dir_x, dir_y;
  logic          border, hit;
  logic [2:0]    rgb_d;

  // First blanking line, column 0; armed_q masks a tick on the cycle reset releases
  always_comb begin
    tick   = (vpos == VTick) && (hpos == '0);
    accept = tick && !pause && armed_q && (state_q == IDLE);
  end

  // Goes high one cycle after reset deasserts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) armed_q <= 1'b0;
    else       armed_q <= 1'b1;
  end

  // Update sequencer: x then y, once per accepted tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = UPD_X;
      UPD_X:   state_d = UPD_Y;
      UPD_Y:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  bounce_axis #(
    .WIDTH (HW),
    .LIM   (H_DISPLAY - BALL_SIZE),
    .SPEED (SPEED),
    .START (START_X)
  ) u_axis_x (
    .clk   (clk),
    .reset (reset),
    .step  (state_q == UPD_X),
    .pos   (ball_x),
    .dir   (dir_x)
  );

  bounce_axis #(
    .WIDTH (VW),
    .LIM   (V_DISPLAY - BALL_SIZE),
    .SPEED (SPEED),
    .START (START_Y)
  ) u_axis_y (
    .clk   (clk),
    .reset (reset),
    .step  (state_q == UPD_Y),
    .pos   (ball_y),
    .dir   (dir_y)
  );

  // Pixel classification; border wins over ball
  always_comb begin
    border = (hpos == '0) || (hpos == HLast) || (vpos == '0) || (vpos == VLast);
    hit    = (hpos >= ball_x) && (hpos < ball_x + BallH) &&
             (vpos >= ball_y) && (vpos < ball_y + BallV);
    if (!display_on)  rgb_d = COL_BLACK;
    else if (border)  rgb_d = COL_BORDER;
    else if (hit)     rgb_d = COL_BALL;
    else              rgb_d = COL_BG;
  end

  // Output registers keep rgb and syncs aligned at the pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb   <= COL_BLACK;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      rgb   <= rgb_d;
      hsync <= hsync_in;
      vsync <= vsync_in;
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
module tb_ball_renderer;

  localparam logic [2:0] K = 3'b000;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] W = 3'b111;
  localparam logic [2:0] B = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync_in, vsync_in, display_on, pause;
  logic [9:0] hpos, vpos;
  logic       hsync, vsync;
  logic [2:0] rgb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         h;
    int         v;
    logic       de;
    logic [2:0] exp;
  } pix_vec_t;

  pix_vec_t vecs[13];

  ball_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .pause      (pause),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    hpos       = 10'd1;
    vpos       = 10'd500;
    display_on = 1'b0;
  endtask

  // Present one pixel, sample its registered colour one cycle later
  task automatic pixel(input int h, input int v, input logic [2:0] exp, input string name);
    @(negedge clk);
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("%s rgb@(%0d,%0d)", name, h, v), int'(rgb), int'(exp));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hpos       = 10'd0;
      vpos       = 10'd480;
      display_on = 1'b0;
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
    end
  endtask

  // Pin the ball's four edges by probing just inside and just outside each one
  task automatic check_ball(input int ex, input int ey, input string name);
    int cx, cy;
    cx = ex + 8;
    cy = ey + 8;
    if (ex >= 1)       pixel(ex, cy, W, {name, " left in"});
    if (ex >= 2)       pixel(ex - 1, cy, B, {name, " left out"});
    if (ex + 15 <= 638) pixel(ex + 15, cy, W, {name, " right in"});
    if (ex + 16 <= 638) pixel(ex + 16, cy, B, {name, " right out"});
    if (ey >= 1)       pixel(cx, ey, W, {name, " top in"});
    if (ey >= 2)       pixel(cx, ey - 1, B, {name, " top out"});
    if (ey + 15 <= 478) pixel(cx, ey + 15, W, {name, " bottom in"});
    if (ey + 16 <= 478) pixel(cx, ey + 16, B, {name, " bottom out"});
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = '{100, 80,  1'b1, W};
    vecs[1]  = '{0,   0,   1'b1, G};
    vecs[2]  = '{50,  50,  1'b1, B};
    vecs[3]  = '{115, 95,  1'b1, W};
    vecs[4]  = '{116, 80,  1'b1, B};
    vecs[5]  = '{639, 10,  1'b1, G};
    vecs[6]  = '{100, 95,  1'b1, W};
    vecs[7]  = '{100, 96,  1'b1, B};
    vecs[8]  = '{10,  479, 1'b1, G};
    vecs[9]  = '{99,  80,  1'b1, B};
    vecs[10] = '{100, 80,  1'b0, K};
    vecs[11] = '{108, 88,  1'b1, W};
    vecs[12] = '{100, 79,  1'b1, B};

    // Reset held 3 cycles with live inputs; outputs must stay 0
    reset      = 1'b1;
    pause      = 1'b0;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    display_on = 1'b1;
    hpos       = 10'd100;
    vpos       = 10'd80;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset rgb", int'(rgb), 0);
      check("reset hsync", int'(hsync), 0);
      check("reset vsync", int'(vsync), 0);
    end

    // Release reset with a tick on the same cycle: tick must be ignored
    @(negedge clk);
    reset      = 1'b0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    hpos       = 10'd0;
    vpos       = 10'd480;
    display_on = 1'b0;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check_ball(100, 80, "tick at release");

    // Back-to-back pixel vectors: each must land exactly one cycle later
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      hpos       = 10'(vecs[i].h);
      vpos       = 10'(vecs[i].v);
      display_on = vecs[i].de;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rgb", i), int'(rgb), int'(vecs[i].exp));
    end
    @(negedge clk);
    idle_inputs();

    // Sync latency
    @(negedge clk);
    hsync_in = 1'b1;
    check("hsync before", int'(hsync), 0);
    @(posedge clk);
    #1;
    check("hsync delayed", int'(hsync), 1);
    @(negedge clk);
    hsync_in = 1'b0;
    vsync_in = 1'b1;
    @(posedge clk);
    #1;
    check("hsync end", int'(hsync), 0);
    check("vsync delayed", int'(vsync), 1);
    @(negedge clk);
    vsync_in = 1'b0;
    @(posedge clk);
    #1;
    check("vsync end", int'(vsync), 0);

    // Pause across 3 ticks freezes the ball
    pause = 1'b1;
    tick_n(3);
    check_ball(100, 80, "paused");
    pause = 1'b0;
    tick_n(1);
    check_ball(102, 82, "unpaused");

    // Pause raised after the tick is accepted does not abort the update
    @(negedge clk);
    hpos = 10'd0;
    vpos = 10'd480;
    @(negedge clk);
    idle_inputs();
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    check_ball(104, 84, "late pause");

    // Reset while in UPD_X: all motion state returns to start
    @(negedge clk);
    hpos = 10'd0;
    vpos = 10'd480;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_ball(100, 80, "reset mid-update");
    tick_n(1);
    check_ball(102, 82, "after mid-update reset");

    // Clean start for the bounce run
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tick_n(192);
    check_ball(484, 464, "bottom bounce");
    tick_n(1);
    check_ball(486, 462, "after bottom");
    tick_n(69);
    check_ball(624, 324, "right bounce");
    tick_n(1);
    check_ball(622, 322, "after right");
    tick_n(161);
    check_ball(300, 0, "top bounce");
    tick_n(150);
    check_ball(0, 300, "left bounce");
    tick_n(1);
    check_ball(2, 302, "after left");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
